ui_controller_ex: RTL and testbench

- Parameterised memory-mapped UI controller: debounced keys/switches, LED and hex-digit output registers, sticky edge-capture registers, and a level interrupt.
- Sits on the processor's UI I/O path, selected by a 3-bit device code.
- Supersedes the fixed 4-key/10-switch/4-digit UI controller: adds debouncing, edge capture with write-1-to-clear, per-digit blanking and IRQ generation.

---
 rtl/ui_pkg.sv | 45 ++++
 rtl/ui_debouncer.sv | 70 +++++++
 rtl/ui_controller_ex.sv | 130 +++++++++++++
 tb/tb_ui_controller_ex.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared definitions for the UI controller: register map codes, CTRL bit
// positions and the seven-segment decode used for every hex digit.
package ui_pkg;

    localparam logic [2:0] UI_KEY      = 3'd0;
    localparam logic [2:0] UI_SW       = 3'd1;
    localparam logic [2:0] UI_LEDR     = 3'd2;
    localparam logic [2:0] UI_HEX      = 3'd3;
    localparam logic [2:0] UI_KEY_EDGE = 3'd4;
    localparam logic [2:0] UI_SW_EDGE  = 3'd5;
    localparam logic [2:0] UI_CTRL     = 3'd6;
    localparam logic [2:0] UI_STATUS   = 3'd7;

    localparam int CTRL_KEY_IE    = 0;
    localparam int CTRL_SW_IE     = 1;
    localparam int CTRL_BLANK_LSB = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segments are active-low, bit order gfedcba.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ui_debouncer.sv
// Two-flop synchroniser plus tick-sampled debouncer for a bank of raw inputs.
// Emits the debounced level and single-cycle rise/change pulses.
module ui_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] change
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] sample_r;
    logic [WIDTH-1:0] level_r;
    logic [CW-1:0]    cnt_r;
    logic             primed_r;
    logic             tick_s;
    logic [WIDTH-1:0] upd_s;

    assign tick_s = (cnt_r == TICK_LAST);

    // A bit flips only when this sample matches the previous one and differs from the level.
    always_comb begin
        upd_s = {WIDTH{1'b0}};
        if (tick_s && primed_r) begin
            upd_s = ~(sync2_r ^ sample_r) & (sync2_r ^ level_r);
        end else begin
            upd_s = {WIDTH{1'b0}};
        end
    end

    // Synchroniser, tick counter and level state; the first tick loads levels silently.
    always_ff @(negedge clk) begin
        if (!reset) begin
            sync1_r  <= {WIDTH{1'b0}};
            sync2_r  <= {WIDTH{1'b0}};
            sample_r <= {WIDTH{1'b0}};
            level_r  <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            primed_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (tick_s) begin
                cnt_r    <= {CW{1'b0}};
                sample_r <= sync2_r;
                primed_r <= 1'b1;
                if (!primed_r) begin
                    level_r <= sync2_r;
                end else begin
                    level_r <= level_r ^ upd_s;
                end
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level  = level_r;
    assign rise   = upd_s & sync2_r;
    assign change = upd_s;

endmodule

// File: rtl/ui_controller_ex.sv
// Memory-mapped UI controller: debounced keys/switches, LED and hex registers,
// sticky W1C edge capture and a level interrupt.
module ui_controller_ex
    import ui_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int N_KEY           = 4,
    parameter int N_SW            = 10,
    parameter int N_LED           = 10,
    parameter int N_HEX           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wrtEn,
    input  logic [DBITS-1:0]   in,
    input  logic [2:0]         uiDevice,
    input  logic [N_KEY-1:0]   KEYS,
    input  logic [N_SW-1:0]    SWITCHES,
    output logic [DBITS-1:0]   out,
    output logic               irq,
    output logic [N_LED-1:0]   LED,
    output logic [7*N_HEX-1:0] HEX
);

    logic [N_LED-1:0]   led_r;
    logic [4*N_HEX-1:0] hex_r;
    logic [N_HEX+1:0]   ctrl_r;
    logic [N_KEY-1:0]   key_edge_r;
    logic [N_SW-1:0]    sw_edge_r;

    logic [N_KEY-1:0]   key_raw_s;
    logic [N_KEY-1:0]   key_level_s;
    logic [N_KEY-1:0]   key_rise_s;
    logic [N_KEY-1:0]   key_chg_unused_s;
    logic [N_SW-1:0]    sw_level_s;
    logic [N_SW-1:0]    sw_rise_unused_s;
    logic [N_SW-1:0]    sw_change_s;
    logic [N_KEY-1:0]   key_clr_s;
    logic [N_SW-1:0]    sw_clr_s;
    logic               irq_s;
    logic [DBITS-1:0]   rd_s;
    logic               in_unused_s;

    assign key_raw_s   = (KEY_ACTIVE_LOW != 0) ? ~KEYS : KEYS;
    assign in_unused_s = ^in;

    ui_debouncer #(.WIDTH(N_KEY), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (key_raw_s),
        .level  (key_level_s),
        .rise   (key_rise_s),
        .change (key_chg_unused_s)
    );

    ui_debouncer #(.WIDTH(N_SW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (SWITCHES),
        .level  (sw_level_s),
        .rise   (sw_rise_unused_s),
        .change (sw_change_s)
    );

    // Write-1-to-clear masks for the sticky edge registers.
    always_comb begin
        key_clr_s = {N_KEY{1'b0}};
        sw_clr_s  = {N_SW{1'b0}};
        if (wrtEn && (uiDevice == UI_KEY_EDGE)) begin
            key_clr_s = in[N_KEY-1:0];
        end else if (wrtEn && (uiDevice == UI_SW_EDGE)) begin
            sw_clr_s = in[N_SW-1:0];
        end else begin
            key_clr_s = {N_KEY{1'b0}};
            sw_clr_s  = {N_SW{1'b0}};
        end
    end

    // Register file; an edge set in the same cycle as its clear survives.
    always_ff @(negedge clk) begin
        if (!reset) begin
            led_r      <= {N_LED{1'b0}};
            hex_r      <= {(4*N_HEX){1'b0}};
            ctrl_r     <= {(N_HEX+2){1'b0}};
            key_edge_r <= {N_KEY{1'b0}};
            sw_edge_r  <= {N_SW{1'b0}};
        end else begin
            key_edge_r <= (key_edge_r & ~key_clr_s) | key_rise_s;
            sw_edge_r  <= (sw_edge_r & ~sw_clr_s) | sw_change_s;
            if (wrtEn) begin
                case (uiDevice)
                    UI_LEDR: led_r  <= in[N_LED-1:0];
                    UI_HEX:  hex_r  <= in[4*N_HEX-1:0];
                    UI_CTRL: ctrl_r <= in[N_HEX+1:0];
                    default: led_r  <= led_r;
                endcase
            end
        end
    end

    assign irq_s = (ctrl_r[CTRL_KEY_IE] & (|key_edge_r)) | (ctrl_r[CTRL_SW_IE] & (|sw_edge_r));

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_s = {DBITS{1'b0}};
        case (uiDevice)
            UI_KEY:      rd_s[N_KEY-1:0]   = key_level_s;
            UI_SW:       rd_s[N_SW-1:0]    = sw_level_s;
            UI_LEDR:     rd_s[N_LED-1:0]   = led_r;
            UI_HEX:      rd_s[4*N_HEX-1:0] = hex_r;
            UI_KEY_EDGE: rd_s[N_KEY-1:0]   = key_edge_r;
            UI_SW_EDGE:  rd_s[N_SW-1:0]    = sw_edge_r;
            UI_CTRL:     rd_s[N_HEX+1:0]   = ctrl_r;
            UI_STATUS:   rd_s[2:0]         = {irq_s, |sw_edge_r, |key_edge_r};
            default:     rd_s              = {DBITS{1'b0}};
        endcase
    end

    assign out = rd_s;
    assign irq = irq_s;
    assign LED = led_r;

    for (genvar i = 0; i < N_HEX; i++) begin : g_digit
        assign HEX[7*i +: 7] = ctrl_r[CTRL_BLANK_LSB + i] ? SEG_BLANK
                                                          : seg7_decode(hex_r[4*i +: 4]);
    end

endmodule

// File: tb/tb_ui_controller_ex.sv
// Scoreboard bench for ui_controller_ex with a short debounce period.
module tb_ui_controller_ex;

    localparam int DBITS = 32;
    localparam int N_KEY = 4;
    localparam int N_SW  = 10;
    localparam int N_LED = 10;
    localparam int N_HEX = 4;
    localparam int DBC   = 4;

    logic               clk;
    logic               reset;
    logic               wrtEn;
    logic [DBITS-1:0]   din;
    logic [2:0]         dev;
    logic [N_KEY-1:0]   keys;
    logic [N_SW-1:0]    switches;
    logic [DBITS-1:0]   dout;
    logic               irq;
    logic [N_LED-1:0]   led;
    logic [7*N_HEX-1:0] hex;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] act;
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          nc       = 0;

    ui_controller_ex #(
        .DBITS(DBITS), .N_KEY(N_KEY), .N_SW(N_SW), .N_LED(N_LED), .N_HEX(N_HEX),
        .DEBOUNCE_CYCLES(DBC), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wrtEn    (wrtEn),
        .in       (din),
        .uiDevice (dev),
        .KEYS     (keys),
        .SWITCHES (switches),
        .out      (dout),
        .irq      (irq),
        .LED      (led),
        .HEX      (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Negedges since reset release; debounce ticks land where nc is a multiple of 4.
    always @(negedge clk) begin
        if (!reset) nc <= 0;
        else        nc <= nc + 1;
    end

    // Monitor: compare every expectation queued in the previous cycle.
    always @(posedge clk) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            case (cur.kind)
                0:       act = dout;
                1:       act = {31'b0, irq};
                2:       act = {4'b0, hex};
                default: act = {22'b0, led};
            endcase
            chk_cnt = chk_cnt + 1;
            if (act === cur.exp) pass_cnt = pass_cnt + 1;
            else $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] e, input string name);
        exp_t x;
        x.kind = kind;
        x.exp  = e;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic rd(input logic [2:0] d, input logic [31:0] e, input string name);
        dev = d;
        push(0, e, name);
        step();
    endtask

    task automatic wr(input logic [2:0] d, input logic [31:0] data);
        dev   = d;
        din   = data;
        wrtEn = 1'b1;
        step();
        wrtEn = 1'b0;
        din   = 32'h0;
    endtask

    task automatic align();
        do step(); while (nc % 4 != 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; wrtEn = 1'b0; din = 32'h0; dev = 3'd0;
        keys = 4'hF; switches = 10'h3FF;
        step();
        // Reset state; a write while in reset must be ignored.
        wr(3'd2, 32'hFFFFFFFF);
        rd(3'd2, 32'h0, "rst_led");
        rd(3'd3, 32'h0, "rst_hex");
        rd(3'd4, 32'h0, "rst_key_edge");
        rd(3'd5, 32'h0, "rst_sw_edge");
        rd(3'd6, 32'h0, "rst_ctrl");
        push(2, 32'h08102040, "rst_hex_seg");
        push(1, 32'h0, "rst_irq");
        rd(3'd7, 32'h0, "rst_status");
        reset = 1'b1;
        repeat (12) step();
        rd(3'd5, 32'h0, "prime_no_sw_edge");
        rd(3'd1, 32'h3FF, "prime_sw_level");
        rd(3'd0, 32'h0, "prime_key_level");

        // Key 1 glitches, then settles pressed.
        align();
        keys = 4'b1101; step();
        keys = 4'b1111; step();
        keys = 4'b1101; step();
        keys = 4'b1111; step();
        keys = 4'b1101;
        repeat (6) step();
        rd(3'd0, 32'h0, "db_not_yet");
        rd(3'd0, 32'h2, "db_accepted");
        rd(3'd4, 32'h2, "db_key_edge");

        // W1C and interrupt.
        wr(3'd6, 32'h1);
        keys = 4'b1001;
        repeat (16) step();
        push(1, 32'h1, "irq_two_edges");
        rd(3'd4, 32'h6, "key_edge_0110");
        rd(3'd7, 32'h5, "status_key");
        wr(3'd4, 32'h2);
        push(1, 32'h1, "irq_one_edge");
        rd(3'd4, 32'h4, "w1c_bit1");
        wr(3'd4, 32'h4);
        push(1, 32'h0, "irq_cleared");
        rd(3'd4, 32'h0, "w1c_bit2");

        // Release key 1, then re-press so the capture lands on a W1C write of bit 1.
        keys = 4'b1011;
        repeat (16) step();
        rd(3'd4, 32'h0, "release_no_edge");
        align();
        keys = 4'b1001;
        repeat (7) step();
        wr(3'd4, 32'h2);
        rd(3'd4, 32'h2, "set_wins");
        rd(3'd0, 32'h6, "key_level_0110");

        // Hex decode and blanking.
        wr(3'd3, 32'h0000ABCD);
        push(2, 32'h0100E321, "hex_abcd");
        rd(3'd3, 32'h0000ABCD, "hex_readback");
        wr(3'd6, 32'h4);
        push(2, 32'h0100E37F, "hex_blank0");
        push(1, 32'h0, "irq_ie_off");
        rd(3'd6, 32'h4, "ctrl_readback");

        // Width truncation and read-only device.
        wr(3'd2, 32'hFFFFFFFF);
        push(3, 32'h3FF, "led_port");
        rd(3'd2, 32'h3FF, "led_trunc");
        wr(3'd0, 32'hFFFFFFFF);
        rd(3'd0, 32'h6, "key_ro");

        // Switch change capture and switch interrupt.
        switches = 10'h3FE;
        repeat (16) step();
        rd(3'd5, 32'h1, "sw_edge");
        wr(3'd6, 32'h6);
        push(1, 32'h1, "irq_sw");
        rd(3'd7, 32'h7, "status_all");
        rd(3'd1, 32'h3FE, "sw_level");

        // Reset mid-tick discards everything; re-priming creates no edges.
        reset = 1'b0;
        rd(3'd2, 32'h0, "mid_rst_led");
        reset = 1'b1;
        chk_cnt = chk_cnt + 1;
        if (led === 10'h0) pass_cnt = pass_cnt + 1;
        else $display("FAIL mid_rst_led_port: got %h expected %h", led, 10'h0);
        push(1, 32'h0, "mid_rst_irq");
        push(2, 32'h08102040, "mid_rst_hex");
        rd(3'd1, 32'h0, "mid_rst_sw_level");
        rd(3'd6, 32'h0, "mid_rst_ctrl");
        repeat (12) step();
        rd(3'd5, 32'h0, "reprime_sw_edge");
        rd(3'd4, 32'h0, "reprime_key_edge");
        rd(3'd0, 32'h6, "reprime_key_level");
        rd(3'd1, 32'h3FE, "reprime_sw_level");

        repeat (3) step();
        chk_cnt = chk_cnt + 1;
        if (dout === 32'h3FE) pass_cnt = pass_cnt + 1;
        else $display("FAIL final_sw_read: got %h expected %h", dout, 32'h3FE);
        if (exp_q.size() != 0)
            $display("FAIL queue_drained: got %0d expected 0", exp_q.size());
        if (chk_cnt < 12)
            $display("FAIL check_count: got %0d expected at least 12", chk_cnt);
        if (pass_cnt != chk_cnt)
            $display("FAIL summary: got %0d expected %0d", pass_cnt, chk_cnt);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
